// File: rtl/cmd_write_master_if.sv
// rtl/cmd_write_master_if.sv - AXI4-Lite write-channel bundle between command initiator and slave
interface cmd_write_master_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);
  logic [ADDR_WIDTH-1:0]   oAWADDR;
  logic [2:0]              oAWPROT;
  logic                    oAWVALID;
  logic                    iAWREADY;
  logic [DATA_WIDTH-1:0]   oWDATA;
  logic [DATA_WIDTH/8-1:0] oWSTRB;
  logic                    oWVALID;
  logic                    iWREADY;
  logic                    oBREADY;
  logic [1:0]              iBRESP;
  logic                    iBVALID;

  modport master (
    output oAWADDR, oAWPROT, oAWVALID, oWDATA, oWSTRB, oWVALID, oBREADY,
    input  iAWREADY, iWREADY, iBRESP, iBVALID
  );

  modport slave (
    input  oAWADDR, oAWPROT, oAWVALID, oWDATA, oWSTRB, oWVALID, oBREADY,
    output iAWREADY, iWREADY, iBRESP, iBVALID
  );
endinterface

// File: rtl/cmd_write_master.sv
// rtl/cmd_write_master.sv - FIFO-fed AXI4-Lite single-beat write initiator with bounded retry
module cmd_write_master #(
  parameter int                    ADDR_WIDTH  = 32,
  parameter int                    DATA_WIDTH  = 32,
  parameter int                    FIFO_DEPTH  = 8,
  parameter logic [ADDR_WIDTH-1:0] TARGET_ADDR = ADDR_WIDTH'(1),
  parameter int                    MAX_RETRY   = 3
) (
  input  logic                  ACLK,
  input  logic                  reset,
  input  logic [DATA_WIDTH-1:0] cmd_data,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  cmd_write_master_if.master    axi,
  output logic                  busy,
  output logic                  drop_pulse,
  output logic [7:0]            err_count
);

  localparam int         IW    = $clog2(FIFO_DEPTH);
  localparam int         PW    = IW + 1;
  localparam logic [3:0] MAX_R = 4'(MAX_RETRY);

  typedef enum logic [1:0] {IDLE, ADDR_DATA, RESP} state_t;

  // FIFO storage and pointers (extra MSB distinguishes full from empty)
  logic [DATA_WIDTH-1:0] mem_q [FIFO_DEPTH];
  logic [PW-1:0]         wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]         rd_ptr_q, rd_ptr_d;
  logic                  full, empty, push, pop;

  // Transaction state
  state_t     state_q, state_d;
  logic       awvalid_q, awvalid_d;
  logic       wvalid_q, wvalid_d;
  logic       aw_done_q, aw_done_d;
  logic       w_done_q, w_done_d;
  logic       bready_q, bready_d;
  logic [3:0] retry_q, retry_d;
  logic       drop_q, drop_d;
  logic [7:0] err_q, err_d;
  logic       aw_hs, w_hs, b_hs;

  assign empty = (wr_ptr_q == rd_ptr_q);
  assign full  = (wr_ptr_q[IW] != rd_ptr_q[IW]) &&
                 (wr_ptr_q[IW-1:0] == rd_ptr_q[IW-1:0]);
  assign push  = cmd_valid & ~full;

  assign wr_ptr_d = wr_ptr_q + {{(PW-1){1'b0}}, push};
  assign rd_ptr_d = rd_ptr_q + {{(PW-1){1'b0}}, pop};

  assign aw_hs = awvalid_q & axi.iAWREADY;
  assign w_hs  = wvalid_q & axi.iWREADY;
  assign b_hs  = bready_q & axi.iBVALID;

  assign cmd_ready    = ~full;
  assign busy         = ~empty | (state_q != IDLE);
  assign drop_pulse   = drop_q;
  assign err_count    = err_q;
  assign axi.oAWADDR  = TARGET_ADDR;
  assign axi.oAWPROT  = 3'b000;
  assign axi.oAWVALID = awvalid_q;
  assign axi.oWDATA   = mem_q[rd_ptr_q[IW-1:0]];
  assign axi.oWSTRB   = '1;
  assign axi.oWVALID  = wvalid_q;
  assign axi.oBREADY  = bready_q;

  // FIFO storage: cleared on reset so the head word reads as zero when empty
  always_ff @(posedge ACLK or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
    end else if (push) begin
      mem_q[wr_ptr_q[IW-1:0]] <= cmd_data;
    end
  end

  // State register for pointers, FSM and channel flags
  always_ff @(posedge ACLK or posedge reset) begin
    if (reset) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      state_q   <= IDLE;
      awvalid_q <= 1'b0;
      wvalid_q  <= 1'b0;
      aw_done_q <= 1'b0;
      w_done_q  <= 1'b0;
      bready_q  <= 1'b0;
      retry_q   <= '0;
      drop_q    <= 1'b0;
      err_q     <= '0;
    end else begin
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      state_q   <= state_d;
      awvalid_q <= awvalid_d;
      wvalid_q  <= wvalid_d;
      aw_done_q <= aw_done_d;
      w_done_q  <= w_done_d;
      bready_q  <= bready_d;
      retry_q   <= retry_d;
      drop_q    <= drop_d;
      err_q     <= err_d;
    end
  end

  // Next-state: issue AW/W together, wait for both, then resolve the B response
  always_comb begin
    state_d   = state_q;
    awvalid_d = awvalid_q;
    wvalid_d  = wvalid_q;
    aw_done_d = aw_done_q;
    w_done_d  = w_done_q;
    bready_d  = bready_q;
    retry_d   = retry_q;
    drop_d    = 1'b0;
    err_d     = err_q;
    pop       = 1'b0;
    case (state_q)
      IDLE: begin
        if (!empty) begin
          state_d   = ADDR_DATA;
          awvalid_d = 1'b1;
          wvalid_d  = 1'b1;
          aw_done_d = 1'b0;
          w_done_d  = 1'b0;
        end
      end
      ADDR_DATA: begin
        if (aw_hs) begin
          awvalid_d = 1'b0;
          aw_done_d = 1'b1;
        end
        if (w_hs) begin
          wvalid_d = 1'b0;
          w_done_d = 1'b1;
        end
        if ((aw_done_q | aw_hs) && (w_done_q | w_hs)) begin
          state_d  = RESP;
          bready_d = 1'b1;
        end
      end
      RESP: begin
        if (b_hs) begin
          bready_d = 1'b0;
          if (axi.iBRESP == 2'b00) begin
            pop     = 1'b1;
            retry_d = '0;
            state_d = IDLE;
          end else if (retry_q < MAX_R) begin
            // Head word is still in the FIFO, so the resend carries identical data
            retry_d   = retry_q + 4'd1;
            state_d   = ADDR_DATA;
            awvalid_d = 1'b1;
            wvalid_d  = 1'b1;
            aw_done_d = 1'b0;
            w_done_d  = 1'b0;
          end else begin
            pop     = 1'b1;
            drop_d  = 1'b1;
            err_d   = (err_q == 8'hFF) ? err_q : err_q + 8'd1;
            retry_d = '0;
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_cmd_write_master.sv
// tb/tb_cmd_write_master.sv - directed self-checking bench for cmd_write_master
module tb_cmd_write_master;

  logic        ACLK = 1'b0;
  logic        reset;
  logic [31:0] cmd_data;
  logic        cmd_valid;
  logic        cmd_ready;
  logic        busy;
  logic        drop_pulse;
  logic [7:0]  err_count;
  logic        b_en;
  logic [1:0]  resp_arr [64];

  int n_cmp = 0;
  int n_bad = 0;
  int aw_cnt = 0;
  int w_cnt = 0;
  int b_cnt = 0;
  int drop_cnt = 0;
  logic [31:0] wlog [64];

  cmd_write_master_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) bus ();

  cmd_write_master dut (
    .ACLK       (ACLK),
    .reset      (reset),
    .cmd_data   (cmd_data),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .axi        (bus),
    .busy       (busy),
    .drop_pulse (drop_pulse),
    .err_count  (err_count)
  );

  always #5 ACLK = ~ACLK;

  assign bus.iBVALID = b_en & bus.oBREADY;
  assign bus.iBRESP  = resp_arr[b_cnt[5:0]];

  // Slave-side monitor: records every handshake seen at the clock edge
  always @(posedge ACLK) begin
    if (bus.oAWVALID && bus.iAWREADY) aw_cnt <= aw_cnt + 1;
    if (bus.oWVALID && bus.iWREADY) begin
      wlog[w_cnt[5:0]] <= bus.oWDATA;
      w_cnt <= w_cnt + 1;
    end
    if (bus.oBREADY && bus.iBVALID) b_cnt <= b_cnt + 1;
    if (drop_pulse) drop_cnt <= drop_cnt + 1;
  end

  task automatic push(input logic [31:0] d);
    cmd_data  = d;
    cmd_valid = 1'b1;
    @(negedge ACLK);
    cmd_valid = 1'b0;
  endtask

  task automatic wait_idle(input int max, input string tag);
    int k;
    k = 0;
    while (busy && k < max) begin
      @(negedge ACLK);
      k++;
    end
    n_cmp++;
    if (busy !== 1'b0) begin n_bad++; $display("FAIL %s_timeout: busy=%b after %0d cycles, expected 0", tag, busy, max); end
  endtask

  task automatic test_reset();
    n_cmp++; if (bus.oAWVALID !== 1'b0) begin n_bad++; $display("FAIL rst_awvalid: got %b expected 0", bus.oAWVALID); end
    n_cmp++; if (bus.oWVALID !== 1'b0) begin n_bad++; $display("FAIL rst_wvalid: got %b expected 0", bus.oWVALID); end
    n_cmp++; if (bus.oBREADY !== 1'b0) begin n_bad++; $display("FAIL rst_bready: got %b expected 0", bus.oBREADY); end
    n_cmp++; if (drop_pulse !== 1'b0) begin n_bad++; $display("FAIL rst_drop: got %b expected 0", drop_pulse); end
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL rst_busy: got %b expected 0", busy); end
    n_cmp++; if (err_count !== 8'd0) begin n_bad++; $display("FAIL rst_err: got %0d expected 0", err_count); end
    n_cmp++; if (cmd_ready !== 1'b1) begin n_bad++; $display("FAIL rst_cmd_ready: got %b expected 1", cmd_ready); end
    n_cmp++; if (bus.oAWADDR !== 32'd1) begin n_bad++; $display("FAIL rst_awaddr: got %h expected 00000001", bus.oAWADDR); end
    n_cmp++; if (bus.oAWPROT !== 3'b000) begin n_bad++; $display("FAIL rst_awprot: got %b expected 000", bus.oAWPROT); end
    n_cmp++; if (bus.oWSTRB !== 4'hF) begin n_bad++; $display("FAIL rst_wstrb: got %h expected f", bus.oWSTRB); end
    n_cmp++; if (bus.oWDATA !== 32'h0) begin n_bad++; $display("FAIL rst_wdata: got %h expected 00000000", bus.oWDATA); end
  endtask

  task automatic test_single();
    int a0, w0;
    a0 = aw_cnt; w0 = w_cnt;
    bus.iAWREADY = 1'b1; bus.iWREADY = 1'b1; b_en = 1'b1;
    push(32'hA5A5_0001);
    n_cmp++; if (bus.oAWVALID !== 1'b0) begin n_bad++; $display("FAIL single_early_valid: got %b expected 0", bus.oAWVALID); end
    n_cmp++; if (busy !== 1'b1) begin n_bad++; $display("FAIL single_busy: got %b expected 1", busy); end
    @(negedge ACLK);
    n_cmp++; if (bus.oAWVALID !== 1'b1) begin n_bad++; $display("FAIL single_awvalid: got %b expected 1", bus.oAWVALID); end
    n_cmp++; if (bus.oWVALID !== 1'b1) begin n_bad++; $display("FAIL single_wvalid: got %b expected 1", bus.oWVALID); end
    n_cmp++; if (bus.oWDATA !== 32'hA5A5_0001) begin n_bad++; $display("FAIL single_wdata: got %h expected a5a50001", bus.oWDATA); end
    @(negedge ACLK);
    n_cmp++; if (bus.oAWVALID !== 1'b0) begin n_bad++; $display("FAIL single_aw_drop: got %b expected 0", bus.oAWVALID); end
    n_cmp++; if (bus.oBREADY !== 1'b1) begin n_bad++; $display("FAIL single_bready: got %b expected 1", bus.oBREADY); end
    @(negedge ACLK);
    n_cmp++; if (bus.oBREADY !== 1'b0) begin n_bad++; $display("FAIL single_bready_low: got %b expected 0", bus.oBREADY); end
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL single_busy_end: got %b expected 0", busy); end
    n_cmp++; if (aw_cnt - a0 !== 1) begin n_bad++; $display("FAIL single_aw_count: got %0d expected 1", aw_cnt - a0); end
    n_cmp++; if (wlog[w0[5:0]] !== 32'hA5A5_0001) begin n_bad++; $display("FAIL single_logged: got %h expected a5a50001", wlog[w0[5:0]]); end
  endtask

  task automatic test_skew();
    int a0, w0;
    a0 = aw_cnt; w0 = w_cnt;
    bus.iAWREADY = 1'b0; bus.iWREADY = 1'b0; b_en = 1'b1;
    push(32'h5EED_0002);
    @(negedge ACLK);
    bus.iAWREADY = 1'b1;
    @(negedge ACLK);
    bus.iAWREADY = 1'b0;
    n_cmp++; if (bus.oAWVALID !== 1'b0) begin n_bad++; $display("FAIL skew_aw_drop: got %b expected 0", bus.oAWVALID); end
    n_cmp++; if (bus.oWVALID !== 1'b1) begin n_bad++; $display("FAIL skew_w_hold: got %b expected 1", bus.oWVALID); end
    @(negedge ACLK);
    @(negedge ACLK);
    n_cmp++; if (bus.oWDATA !== 32'h5EED_0002) begin n_bad++; $display("FAIL skew_wdata: got %h expected 5eed0002", bus.oWDATA); end
    n_cmp++; if (bus.oBREADY !== 1'b0) begin n_bad++; $display("FAIL skew_bready_early: got %b expected 0", bus.oBREADY); end
    bus.iWREADY = 1'b1;
    @(negedge ACLK);
    bus.iWREADY = 1'b0;
    n_cmp++; if (bus.oWVALID !== 1'b0) begin n_bad++; $display("FAIL skew_w_drop: got %b expected 0", bus.oWVALID); end
    n_cmp++; if (bus.oBREADY !== 1'b1) begin n_bad++; $display("FAIL skew_bready: got %b expected 1", bus.oBREADY); end
    wait_idle(10, "skew");
    n_cmp++; if (aw_cnt - a0 !== 1) begin n_bad++; $display("FAIL skew_aw_count: got %0d expected 1", aw_cnt - a0); end
    n_cmp++; if (w_cnt - w0 !== 1) begin n_bad++; $display("FAIL skew_w_count: got %0d expected 1", w_cnt - w0); end
  endtask

  task automatic test_full();
    int w0;
    logic [31:0] exp;
    w0 = w_cnt;
    bus.iAWREADY = 1'b0; bus.iWREADY = 1'b0; b_en = 1'b1;
    for (int i = 0; i < 8; i++) push(32'hF000_0000 + i);
    n_cmp++; if (cmd_ready !== 1'b0) begin n_bad++; $display("FAIL full_ready: got %b expected 0", cmd_ready); end
    push(32'hDEAD_BEEF);
    n_cmp++; if (cmd_ready !== 1'b0) begin n_bad++; $display("FAIL full_ready_hold: got %b expected 0", cmd_ready); end
    bus.iAWREADY = 1'b1; bus.iWREADY = 1'b1;
    wait_idle(100, "full");
    n_cmp++; if (w_cnt - w0 !== 8) begin n_bad++; $display("FAIL full_w_count: got %0d expected 8", w_cnt - w0); end
    for (int i = 0; i < 8; i++) begin
      exp = 32'hF000_0000 + i;
      n_cmp++; if (wlog[6'(w0 + i)] !== exp) begin n_bad++; $display("FAIL full_order[%0d]: got %h expected %h", i, wlog[6'(w0 + i)], exp); end
    end
    n_cmp++; if (cmd_ready !== 1'b1) begin n_bad++; $display("FAIL full_ready_end: got %b expected 1", cmd_ready); end
  endtask

  task automatic test_retry();
    int a0, w0, d0;
    a0 = aw_cnt; w0 = w_cnt; d0 = drop_cnt;
    resp_arr[6'(b_cnt)]     = 2'b10;
    resp_arr[6'(b_cnt + 1)] = 2'b10;
    resp_arr[6'(b_cnt + 2)] = 2'b00;
    push(32'hC0DE_0003);
    wait_idle(60, "retry");
    n_cmp++; if (aw_cnt - a0 !== 3) begin n_bad++; $display("FAIL retry_aw_count: got %0d expected 3", aw_cnt - a0); end
    for (int i = 0; i < 3; i++) begin
      n_cmp++; if (wlog[6'(w0 + i)] !== 32'hC0DE_0003) begin n_bad++; $display("FAIL retry_data[%0d]: got %h expected c0de0003", i, wlog[6'(w0 + i)]); end
    end
    n_cmp++; if (drop_cnt - d0 !== 0) begin n_bad++; $display("FAIL retry_drop: got %0d expected 0", drop_cnt - d0); end
    n_cmp++; if (err_count !== 8'd0) begin n_bad++; $display("FAIL retry_err: got %0d expected 0", err_count); end
  endtask

  task automatic test_drop();
    int a0, w0, d0;
    logic [31:0] exp;
    a0 = aw_cnt; w0 = w_cnt; d0 = drop_cnt;
    for (int i = 0; i < 4; i++) resp_arr[6'(b_cnt + i)] = 2'b10;
    resp_arr[6'(b_cnt + 4)] = 2'b00;
    push(32'hBAD0_0004);
    push(32'h600D_0005);
    wait_idle(80, "drop");
    n_cmp++; if (aw_cnt - a0 !== 5) begin n_bad++; $display("FAIL drop_aw_count: got %0d expected 5", aw_cnt - a0); end
    for (int i = 0; i < 5; i++) begin
      exp = (i < 4) ? 32'hBAD0_0004 : 32'h600D_0005;
      n_cmp++; if (wlog[6'(w0 + i)] !== exp) begin n_bad++; $display("FAIL drop_data[%0d]: got %h expected %h", i, wlog[6'(w0 + i)], exp); end
    end
    n_cmp++; if (drop_cnt - d0 !== 1) begin n_bad++; $display("FAIL drop_pulse_cycles: got %0d expected 1", drop_cnt - d0); end
    n_cmp++; if (err_count !== 8'd1) begin n_bad++; $display("FAIL drop_err: got %0d expected 1", err_count); end
  endtask

  task automatic test_reset_midop();
    int a0, w0;
    bus.iAWREADY = 1'b0; bus.iWREADY = 1'b0; b_en = 1'b1;
    push(32'h1111_0001);
    push(32'h1111_0002);
    push(32'h1111_0003);
    n_cmp++; if (bus.oWVALID !== 1'b1) begin n_bad++; $display("FAIL mid_pre_wvalid: got %b expected 1", bus.oWVALID); end
    #2 reset = 1'b1;
    #1;
    n_cmp++; if (bus.oAWVALID !== 1'b0) begin n_bad++; $display("FAIL mid_awvalid: got %b expected 0", bus.oAWVALID); end
    n_cmp++; if (bus.oWVALID !== 1'b0) begin n_bad++; $display("FAIL mid_wvalid: got %b expected 0", bus.oWVALID); end
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL mid_busy: got %b expected 0", busy); end
    n_cmp++; if (cmd_ready !== 1'b1) begin n_bad++; $display("FAIL mid_cmd_ready: got %b expected 1", cmd_ready); end
    n_cmp++; if (err_count !== 8'd0) begin n_bad++; $display("FAIL mid_err: got %0d expected 0", err_count); end
    bus.iAWREADY = 1'b1; bus.iWREADY = 1'b1;
    @(negedge ACLK);
    reset = 1'b0;
    a0 = aw_cnt; w0 = w_cnt;
    repeat (8) @(negedge ACLK);
    n_cmp++; if (aw_cnt - a0 !== 0) begin n_bad++; $display("FAIL mid_no_write: got %0d expected 0", aw_cnt - a0); end
    push(32'h1234_5678);
    wait_idle(20, "mid");
    n_cmp++; if (aw_cnt - a0 !== 1) begin n_bad++; $display("FAIL mid_new_write: got %0d expected 1", aw_cnt - a0); end
    n_cmp++; if (wlog[w0[5:0]] !== 32'h1234_5678) begin n_bad++; $display("FAIL mid_new_data: got %h expected 12345678", wlog[w0[5:0]]); end
  endtask

  initial begin
    reset        = 1'b1;
    cmd_valid    = 1'b0;
    cmd_data     = '0;
    bus.iAWREADY = 1'b0;
    bus.iWREADY  = 1'b0;
    b_en         = 1'b0;
    for (int i = 0; i < 64; i++) resp_arr[i] = 2'b00;
    #12;
    test_reset();
    @(negedge ACLK);
    reset = 1'b0;
    @(negedge ACLK);
    test_single();
    test_skew();
    test_full();
    test_retry();
    test_drop();
    test_reset_midop();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
